redmule_tile_iter: RTL and testbench
====================================

REDMULE_TILE_ITER -- requirements
Module: redmule_tile_iter

Interface
REQ-001 SHALL have parameter ITER_W, default 16: width of every iteration count and index.
REQ-002 SHALL have port clk_i, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have port rst_ni, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port clear_i, input, 1: synchronous soft clear.
REQ-005 SHALL have port start_i, input, 1: job start pulse.
REQ-006 SHALL have port m_iters_i, input, ITER_W: X/Y row-tile count (M).
REQ-007 SHALL have port k_iters_i, input, ITER_W: X-column/W-row tile count (K, reduction).
REQ-008 SHALL have port n_iters_i, input, ITER_W: W/Z column-tile count (N).
REQ-009 SHALL have port tile_valid_o, output, 1: current tile descriptor valid.
REQ-010 SHALL have port tile_ready_i, input, 1: consumer (streamer/engine control) accepts the tile.
REQ-011 SHALL have ports m_idx_o, n_idx_o, k_idx_o, output, ITER_W each: current tile indices.
REQ-012 SHALL have ports first_k_o, last_k_o, last_n_o, last_m_o, output, 1 each: boundary flags of the current tile.
REQ-013 SHALL have port store_o, output, 1: Z tile must be stored after this tile (equals last_k_o).
REQ-014 SHALL have port busy_o, output, 1: FSM not IDLE.
REQ-015 SHALL have port done_o, output, 1: one-cycle job-completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 IDLE: on start_i=1, SHALL latch m/k/n_iters_i, zero all indices, and enter RUN if all three counts are nonzero; otherwise enter DONE with no tiles issued.
REQ-018 SHALL ignore start_i in RUN and DONE; latched counts SHALL be unaffected by input changes after latching.
REQ-019 RUN: tile_valid_o SHALL be 1; IDLE/DONE: tile_valid_o SHALL be 0.
REQ-020 A tile is accepted on a cycle with tile_valid_o=1 and tile_ready_i=1; indices and flags SHALL hold stable while tile_valid_o=1 and tile_ready_i=0.
REQ-021 Loop order SHALL be k innermost, then n, then m outermost.
REQ-022 On accept: if k_idx_o<K-1, increment k; else k wraps to 0 and n increments; if n also at N-1, n wraps to 0 and m increments.
REQ-023 On accept of tile (M-1,N-1,K-1), SHALL go to DONE; indices return to 0.
REQ-024 Flags (combinational from indices): first_k_o=(k==0); last_k_o=(k==K-1); last_n_o=(n==N-1); last_m_o=(m==M-1); all flags 0 outside RUN.
REQ-025 store_o SHALL equal last_k_o while tile_valid_o=1, else 0.
REQ-026 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE.
REQ-027 Total accepted tiles per job SHALL be exactly M*N*K; store_o-flagged accepts SHALL be exactly M*N.
REQ-028 Counter compares SHALL use ITER_W-bit unsigned arithmetic; count value 2^ITER_W-1 SHALL be supported without overflow.
REQ-029 busy_o SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-030 start_i coincident with done_o SHALL be ignored (FSM in DONE); a new job requires start_i in IDLE.

Reset
REQ-031 rst_ni=0 SHALL asynchronously force IDLE, all indices and latched counts 0, and all outputs 0.
REQ-032 clear_i=1 SHALL, on the next edge, force the same state as reset, overriding start_i and any accept; done_o SHALL NOT pulse for a cleared job.
REQ-033 Reset or clear during RUN SHALL abort the job with no further tile_valid_o.

Verification
REQ-034 M=2,N=3,K=2, tile_ready_i=1 constant -> 12 consecutive accepts, order (m,n,k)=(0,0,0),(0,0,1),(0,1,0)...(1,2,1); store_o on 6 of them; done_o one cycle after last accept.
REQ-035 M=1,N=1,K=1 -> single tile with first_k_o=last_k_o=last_n_o=last_m_o=store_o=1; done_o next cycle; busy_o 2 cycles.
REQ-036 K=0 (M=4,N=4) -> no tile_valid_o; done_o 1 cycle after start_i.
REQ-037 M=1,N=2,K=3 with tile_ready_i random 30% -> indices/flags stable across every stalled cycle; 6 accepts total.
REQ-038 Assert clear_i at accept 5 of an M=2,N=2,K=2 job -> IDLE next cycle, tile_valid_o=0, no done_o; new start_i with M=N=K=1 runs normally.
REQ-039 rst_ni low mid-RUN, asynchronously between edges -> all outputs 0 immediately; start_i while busy_o=1 has no effect on counts.

Source files
------------

// File: rtl/redmule_tile_iter.sv
// Tile iteration sequencer: walks (m, n, k) tile indices with k innermost and
// hands one tile descriptor at a time to the consumer over a valid/ready handshake.
module redmule_tile_iter #(
    parameter int unsigned ITER_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [ITER_W-1:0] m_iters_i,
    input  logic [ITER_W-1:0] k_iters_i,
    input  logic [ITER_W-1:0] n_iters_i,
    output logic              tile_valid_o,
    input  logic              tile_ready_i,
    output logic [ITER_W-1:0] m_idx_o,
    output logic [ITER_W-1:0] n_idx_o,
    output logic [ITER_W-1:0] k_idx_o,
    output logic              first_k_o,
    output logic              last_k_o,
    output logic              last_n_o,
    output logic              last_m_o,
    output logic              store_o,
    output logic              busy_o,
    output logic              done_o
);

    // Handshake: a tile is transferred on any rising edge where tile_valid_o and
    // tile_ready_i are both high; while valid is high and ready is low, every
    // descriptor output holds its value. valid never drops without a transfer
    // except on reset or clear.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [ITER_W-1:0] ONE = {{(ITER_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ITER_W-1:0] m_cnt_q, k_cnt_q, n_cnt_q;
    logic [ITER_W-1:0] m_idx_q, n_idx_q, k_idx_q;
    logic              counts_ok;
    logic              at_last_k, at_last_n, at_last_m;
    logic              accept, job_last;

    assign counts_ok = (|m_iters_i) & (|k_iters_i) & (|n_iters_i);

    // Compare against count-1 so a count of all ones never needs an extra bit.
    assign at_last_k = (k_idx_q == k_cnt_q - ONE);
    assign at_last_n = (n_idx_q == n_cnt_q - ONE);
    assign at_last_m = (m_idx_q == m_cnt_q - ONE);

    assign accept   = (state_q == RUN) & tile_ready_i;
    assign job_last = at_last_k & at_last_n & at_last_m;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else if (clear_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = counts_ok ? RUN : DONE;
                end
            end
            RUN: begin
                if (accept && job_last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latched counts and tile indices
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_cnt_q <= '0;
            k_cnt_q <= '0;
            n_cnt_q <= '0;
            m_idx_q <= '0;
            n_idx_q <= '0;
            k_idx_q <= '0;
        end else if (clear_i) begin
            m_cnt_q <= '0;
            k_cnt_q <= '0;
            n_cnt_q <= '0;
            m_idx_q <= '0;
            n_idx_q <= '0;
            k_idx_q <= '0;
        end else if (state_q == IDLE && start_i) begin
            m_cnt_q <= m_iters_i;
            k_cnt_q <= k_iters_i;
            n_cnt_q <= n_iters_i;
            m_idx_q <= '0;
            n_idx_q <= '0;
            k_idx_q <= '0;
        end else if (accept) begin
            if (!at_last_k) begin
                k_idx_q <= k_idx_q + ONE;
            end else begin
                k_idx_q <= '0;
                if (!at_last_n) begin
                    n_idx_q <= n_idx_q + ONE;
                end else begin
                    n_idx_q <= '0;
                    // The final tile wraps m too, leaving all indices at zero.
                    m_idx_q <= at_last_m ? '0 : m_idx_q + ONE;
                end
            end
        end
    end

    // Output logic
    always_comb begin
        tile_valid_o = 1'b0;
        first_k_o    = 1'b0;
        last_k_o     = 1'b0;
        last_n_o     = 1'b0;
        last_m_o     = 1'b0;
        store_o      = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        m_idx_o      = m_idx_q;
        n_idx_o      = n_idx_q;
        k_idx_o      = k_idx_q;
        case (state_q)
            RUN: begin
                tile_valid_o = 1'b1;
                first_k_o    = (k_idx_q == '0);
                last_k_o     = at_last_k;
                last_n_o     = at_last_n;
                last_m_o     = at_last_m;
                store_o      = at_last_k;
                busy_o       = 1'b1;
            end
            DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_redmule_tile_iter.sv
// Directed and randomized jobs for redmule_tile_iter, checked against a tile
// list built from nested (m, n, k) loops.
module tb_redmule_tile_iter;

    localparam int W  = 4;
    localparam int TW = 3 * W + 4;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         clear_i;
    logic         start_i;
    logic [W-1:0] m_iters_i, k_iters_i, n_iters_i;
    logic         tile_valid_o;
    logic         tile_ready_i;
    logic [W-1:0] m_idx_o, n_idx_o, k_idx_o;
    logic         first_k_o, last_k_o, last_n_o, last_m_o;
    logic         store_o, busy_o, done_o;

    int checks = 0;
    int errors = 0;

    redmule_tile_iter #(.ITER_W(W)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .start_i      (start_i),
        .m_iters_i    (m_iters_i),
        .k_iters_i    (k_iters_i),
        .n_iters_i    (n_iters_i),
        .tile_valid_o (tile_valid_o),
        .tile_ready_i (tile_ready_i),
        .m_idx_o      (m_idx_o),
        .n_idx_o      (n_idx_o),
        .k_idx_o      (k_idx_o),
        .first_k_o    (first_k_o),
        .last_k_o     (last_k_o),
        .last_n_o     (last_n_o),
        .last_m_o     (last_m_o),
        .store_o      (store_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    // Clock and reset
    always #5 clk_i = ~clk_i;

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TW-1:0] dut_tile();
        return {m_idx_o, n_idx_o, k_idx_o, first_k_o, last_k_o, last_n_o, last_m_o};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_outputs"},
              {tile_valid_o, m_idx_o, n_idx_o, k_idx_o, first_k_o, last_k_o,
               last_n_o, last_m_o, store_o, busy_o, done_o}, '0);
    endtask

    // Driver: runs one job and scores every cycle until done (or clear).
    task automatic run_job(input int m, input int n, input int k, input int pct,
                           input int clear_at);
        logic [TW-1:0] exp_q[$];
        logic [TW-1:0] cur;
        int            exp_tiles, exp_stores;
        int            accepts = 0;
        int            stores = 0;
        int            cyc = 0;
        bit            cleared = 0;
        bit            rdy;
        for (int mi = 0; mi < m; mi++)
            for (int ni = 0; ni < n; ni++)
                for (int ki = 0; ki < k; ki++)
                    exp_q.push_back({W'(mi), W'(ni), W'(ki), ki == 0, ki == k - 1,
                                     ni == n - 1, mi == m - 1});
        exp_tiles  = m * n * k;
        exp_stores = (exp_tiles > 0) ? m * n : 0;

        @(negedge clk_i);
        m_iters_i    = W'(m);
        n_iters_i    = W'(n);
        k_iters_i    = W'(k);
        start_i      = 1'b1;
        tile_ready_i = 1'b0;
        while (1) begin
            @(negedge clk_i);
            cyc++;
            if (cyc > 20 * exp_tiles + 20) begin
                check("timeout", 1, 0);
                start_i      = 1'b0;
                tile_ready_i = 1'b0;
                break;
            end
            if (cleared) begin
                clear_i = 1'b0;
                start_i = 1'b0;
                check("clr_valid", tile_valid_o, 0);
                check("clr_busy", busy_o, 0);
                check("clr_done", done_o, 0);
                @(negedge clk_i);
                check("clr_done_after", {tile_valid_o, done_o}, 0);
                break;
            end
            if (exp_q.size() == 0) begin
                check("done_pulse", {tile_valid_o, busy_o, done_o}, 3'b011);
                check("accept_count", accepts, exp_tiles);
                check("store_count", stores, exp_stores);
                start_i      = 1'b1;
                tile_ready_i = 1'b0;
                @(negedge clk_i);
                check("idle_after_done", {busy_o, done_o, tile_valid_o}, 0);
                start_i = 1'b0;
                break;
            end
            cur = exp_q[0];
            check("valid", tile_valid_o, 1);
            check("tile", dut_tile(), cur);
            check("store", store_o, cur[2]);
            check("busy_done", {busy_o, done_o}, 2'b10);
            rdy       = ($urandom_range(0, 99) < pct);
            start_i   = ($urandom_range(0, 3) == 0);
            m_iters_i = W'($urandom);
            n_iters_i = W'($urandom);
            k_iters_i = W'($urandom);
            if (clear_at != 0 && accepts + 1 == clear_at) begin
                rdy     = 1'b1;
                clear_i = 1'b1;
                cleared = 1'b1;
            end
            tile_ready_i = rdy;
            if (rdy) begin
                accepts++;
                if (cur[2]) stores++;
                void'(exp_q.pop_front());
            end
        end
        tile_ready_i = 1'b0;
    endtask

    initial begin
        rst_ni       = 1'b0;
        clear_i      = 1'b0;
        start_i      = 1'b0;
        tile_ready_i = 1'b0;
        m_iters_i    = '0;
        n_iters_i    = '0;
        k_iters_i    = '0;
        repeat (2) @(negedge clk_i);
        check_all_zero("in_reset");
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_all_zero("after_reset");

        run_job(2, 3, 2, 100, 0);
        run_job(1, 1, 1, 100, 0);
        run_job(4, 4, 0, 100, 0);
        run_job(0, 5, 5, 100, 0);
        run_job(1, 2, 3, 30, 0);
        run_job(2, 2, 2, 100, 5);
        run_job(1, 1, 1, 100, 0);

        // Asynchronous reset between clock edges in the middle of a job.
        @(negedge clk_i);
        m_iters_i = 3; n_iters_i = 3; k_iters_i = 3;
        start_i   = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        tile_ready_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #3 rst_ni = 1'b0;
        #1 check_all_zero("async_reset");
        tile_ready_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_all_zero("post_async_reset");
        run_job(1, 1, 2, 100, 0);

        for (int j = 0; j < 6; j++)
            run_job($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4),
                    $urandom_range(30, 100), 0);

        run_job(1, 2, 15, 60, 0);
        run_job(15, 1, 15, 100, 0);
        run_job(15, 15, 1, 80, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
